// File: rtl/vid_world_pipe.sv
// Purpose: maps pixel row/col to a world-map address and aligns sync/blank/region flags with the returned map pixel.
// Latency: MAP_LAT+1 clocks input-to-output; world_addr is registered one clock after the pixel inputs.
// Backpressure: none; a free-running pixel stream. Optional test pattern: define VID_WORLD_PIPE_TESTPAT_EN.
module vid_world_pipe #(
   parameter int MAP_LAT         = 1,
   parameter int SCALE_SHIFT     = 2,
   parameter int WORLD_BITS      = 7,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic                      clock,
   input  logic                      rst_n,
`ifdef VID_WORLD_PIPE_TESTPAT_EN
   input  logic                      testpat_sel,
`endif
   input  logic                      horiz_sync_in,
   input  logic                      vert_sync_in,
   input  logic                      video_on_in,
   input  logic [9:0]                pixel_row,
   input  logic [9:0]                pixel_column,
   output logic [2*WORLD_BITS-1:0]   world_addr,
   input  logic [1:0]                world_pixel_in,
   output logic                      horiz_sync_out,
   output logic                      vert_sync_out,
   output logic                      video_on_out,
   output logic [1:0]                world_pixel_out,
   output logic                      in_world,
   output logic                      frame_start,
   output logic [15:0]               frame_count
);

   // Flag pipe depth: stage 0 plus MAP_LAT more registers, the last being the output register.
   // The map pixel arrives MAP_LAT clocks after world_addr, i.e. in the same clock as the last
   // flag stage, so world_pixel_out is a mask of world_pixel_in by the registered window flag.
   localparam int          N        = MAP_LAT + 1;
   localparam int          LIM_W    = SCALE_SHIFT + WORLD_BITS;
   localparam logic [31:0] LIMIT    = 32'd1 << LIM_W;
   localparam logic        SYNC_IDL = (SYNC_ACTIVE_LOW != 0);
   localparam logic        SYNC_ACT = ~SYNC_IDL;

   logic [N-1:0] r_hs;
   logic [N-1:0] r_vs;
   logic [N-1:0] r_von;
   logic [N-1:0] r_win;
   // Marks stages holding genuinely sampled data; stays low while the pipe refills after reset.
   logic [N-1:0] r_vld;
   logic [2*WORLD_BITS-1:0] r_addr;
   logic         r_fs;
   logic [15:0]  r_frame_count;
   logic         w_win0;
   logic         w_vs_rise;
   logic [31:0]  w_row_ext;
   logic [31:0]  w_col_ext;

   assign w_row_ext = {22'd0, pixel_row};
   assign w_col_ext = {22'd0, pixel_column};
   assign w_win0    = video_on_in && (w_row_ext < LIMIT) && (w_col_ext < LIMIT);

   // Stage 0 address register and the flag delay line.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_hs   <= {N{SYNC_IDL}};
         r_vs   <= {N{SYNC_IDL}};
         r_von  <= '0;
         r_win  <= '0;
         r_vld  <= '0;
      end else begin
         r_addr <= {pixel_row[LIM_W-1:SCALE_SHIFT], pixel_column[LIM_W-1:SCALE_SHIFT]};
         r_hs   <= {r_hs[N-2:0],  horiz_sync_in};
         r_vs   <= {r_vs[N-2:0],  vert_sync_in};
         r_von  <= {r_von[N-2:0], video_on_in};
         r_win  <= {r_win[N-2:0], w_win0};
         r_vld  <= {r_vld[N-2:0], 1'b1};
      end
   end

   // A rise is counted only when both the old and new output vsync values were really sampled,
   // so the reset-level-to-held-active step during refill never looks like a new frame.
   assign w_vs_rise = r_vld[N-2] && r_vld[N-1] &&
                      (r_vs[N-2] == SYNC_ACT) && (r_vs[N-1] == SYNC_IDL);

   // Frame-start pulse (coincident with vert_sync_out going active) and frame counter.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_fs          <= 1'b0;
         r_frame_count <= 16'd0;
      end else begin
         r_fs <= w_vs_rise;
         if (w_vs_rise) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

`ifdef VID_WORLD_PIPE_TESTPAT_EN
   // Checkerboard select bit (row_cell[3] ^ col_cell[3]) carried alongside the flags.
   logic [N-1:0] r_tp;
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_tp <= '0;
      end else begin
         r_tp <= {r_tp[N-2:0], pixel_row[SCALE_SHIFT+3] ^ pixel_column[SCALE_SHIFT+3]};
      end
   end

   // Mask the map pixel outside the world; substitute the checkerboard when selected.
   always_comb begin
      world_pixel_out = 2'b00;
      if (r_win[N-1]) begin
         if (testpat_sel) begin
            world_pixel_out = r_tp[N-1] ? 2'b01 : 2'b10;
         end else begin
            world_pixel_out = world_pixel_in;
         end
      end
   end
`else
   // Mask the map pixel outside the world and during blanking.
   always_comb begin
      world_pixel_out = 2'b00;
      if (r_win[N-1]) begin
         world_pixel_out = world_pixel_in;
      end
   end
`endif

   assign world_addr     = r_addr;
   assign horiz_sync_out = r_hs[N-1];
   assign vert_sync_out  = r_vs[N-1];
   assign video_on_out   = r_von[N-1];
   assign in_world       = r_win[N-1];
   assign frame_start    = r_fs;
   assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_vid_world_pipe.sv
// Purpose: randomized and directed checks of vid_world_pipe against a cycle-history reference model.
// Latency: model expects world_addr one clock and all aligned outputs two clocks after inputs.
// Backpressure: none; the bench drives one pixel per clock.
module tb_vid_world_pipe;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        hs_i = 1'b1, vs_i = 1'b1, von_i = 1'b0;
   logic [9:0]  row_i = '0, col_i = '0;
   logic [13:0] world_addr;
   logic [1:0]  world_pixel_in = 2'b00;
   logic        hs_o, vs_o, von_o, in_world, frame_start;
   logic [1:0]  pix_o;
   logic [15:0] frame_count;
   logic        tp_sel = 1'b0;

   int total = 0;
   int bad   = 0;

   vid_world_pipe dut (
      .clock(clock), .rst_n(rst_n),
`ifdef VID_WORLD_PIPE_TESTPAT_EN
      .testpat_sel(tp_sel),
`endif
      .horiz_sync_in(hs_i), .vert_sync_in(vs_i), .video_on_in(von_i),
      .pixel_row(row_i), .pixel_column(col_i),
      .world_addr(world_addr), .world_pixel_in(world_pixel_in),
      .horiz_sync_out(hs_o), .vert_sync_out(vs_o), .video_on_out(von_o),
      .world_pixel_out(pix_o), .in_world(in_world),
      .frame_start(frame_start), .frame_count(frame_count)
   );

   always #20 clock = ~clock;

   // Map memory content as a fixed function of the address.
   function automatic logic [1:0] map_val(input logic [13:0] a);
      return ~(a[1:0] ^ a[8:7] ^ a[13:12]);
   endfunction

   // One-clock-latency map memory.
   always @(posedge clock) world_pixel_in <= map_val(world_addr);

   typedef struct packed {
      logic       live;
      logic       hs;
      logic       vs;
      logic       von;
      logic [9:0] row;
      logic [9:0] col;
   } rec_t;

   rec_t        hist[$];
   logic [15:0] mcount = 16'd0;
   int          fs_seen = 0;
   bit          rel_pending = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // k cycles back from the most recent drive; before reset release everything is reset level.
   function automatic rec_t get(input int k);
      rec_t r;
      r = '{live: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b0, row: 10'd0, col: 10'd0};
      if (hist.size() > k) r = hist[hist.size()-1-k];
      return r;
   endfunction

   function automatic logic [13:0] addr_of(input rec_t r);
      return r.live ? {r.row[8:2], r.col[8:2]} : 14'd0;
   endfunction

   function automatic logic win_of(input rec_t r);
      return r.live && r.von && (r.row < 10'd512) && (r.col < 10'd512);
   endfunction

   task automatic compare_all();
      rec_t r1, r2, r3;
      logic [1:0] ep;
      logic efs;
      r1 = get(1); r2 = get(2); r3 = get(3);
      ep = 2'b00;
      if (win_of(r2)) begin
         if (tp_sel) ep = (r2.row[5] ^ r2.col[5]) ? 2'b01 : 2'b10;
         else        ep = map_val(addr_of(r2));
      end
      efs = r2.live && r3.live && !r2.vs && r3.vs;
      if (efs) mcount = mcount + 16'd1;
      check("addr", world_addr, addr_of(r1));
      check("hsync", hs_o, r2.hs);
      check("vsync", vs_o, r2.vs);
      check("video_on", von_o, r2.von);
      check("in_world", in_world, win_of(r2));
      check("pixel", pix_o, ep);
      check("frame_start", frame_start, efs);
      check("frame_count", frame_count, mcount);
      if (frame_start) fs_seen++;
   endtask

   task automatic cycle(input logic hs, input logic vs, input logic von,
                        input logic [9:0] row, input logic [9:0] col);
      rec_t r;
      @(posedge clock);
      #1;
      if (rel_pending) begin
         rst_n = 1'b1;
         rel_pending = 1'b0;
         hist.delete();
      end
      hs_i = hs; vs_i = vs; von_i = von; row_i = row; col_i = col;
      r = '{live: 1'b1, hs: hs, vs: vs, von: von, row: row, col: col};
      hist.push_back(r);
      if (hist.size() > 8) void'(hist.pop_front());
      @(negedge clock);
      compare_all();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"}, world_addr, 0);
      check({tag, "_hs"}, hs_o, 1);
      check({tag, "_vs"}, vs_o, 1);
      check({tag, "_von"}, von_o, 0);
      check({tag, "_pix"}, pix_o, 0);
      check({tag, "_inw"}, in_world, 0);
      check({tag, "_fs"}, frame_start, 0);
      check({tag, "_fc"}, frame_count, 0);
   endtask

   task automatic frames(input int n);
      for (int f = 0; f < n; f++) begin
         for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 10'd490, 10'd0);
         for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 10'd491, 10'd0);
      end
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 10'd492, 10'd0);
   endtask

   function automatic logic [9:0] pick(input logic [9:0] hi, input logic [9:0] lim);
      case ($urandom_range(0, 5))
         0: return 10'd0;
         1: return 10'd511;
         2: return 10'd512;
         3: return hi;
         default: return 10'($urandom_range(0, 32'(lim)));
      endcase
   endfunction

   initial begin
      int vs_left;
      logic cur_vs;
      // Reset state.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_vals("rst");

      // Origin pixel: address one clock later, map value 11 two clocks later.
      rel_pending = 1'b1;
      cycle(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      cycle(1'b1, 1'b1, 1'b1, 10'd4, 10'd4);
      check("t1_addr", world_addr, 14'd0);
      cycle(1'b1, 1'b1, 1'b1, 10'd4, 10'd8);
      check("t1_pix", pix_o, 2'b11);
      check("t1_inw", in_world, 1'b1);

      // Right edge of the world: column 511 inside, 512 outside.
      cycle(1'b1, 1'b1, 1'b1, 10'd479, 10'd511);
      cycle(1'b1, 1'b1, 1'b1, 10'd479, 10'd512);
      check("t2_addr", world_addr, {7'd119, 7'd127});
      cycle(1'b1, 1'b1, 1'b1, 10'd479, 10'd513);
      check("t2_inw511", in_world, 1'b1);
      check("t2_map512", map_val({7'd119, 7'd0}), 2'b11);
      cycle(1'b1, 1'b1, 1'b1, 10'd479, 10'd514);
      check("t2_inw512", in_world, 1'b0);
      check("t2_pix512", pix_o, 2'b00);

      // Three low-true vsync frames.
      fs_seen = 0;
      frames(3);
      check("t3_pulses", fs_seen, 3);
      check("t3_count", frame_count, 16'd3);

      // Randomized traffic with vsync frames.
      cur_vs = 1'b1;
      vs_left = 4;
      for (int i = 0; i < 1500; i++) begin
         if (vs_left == 0) begin
            cur_vs  = ~cur_vs;
            vs_left = cur_vs ? $urandom_range(3, 15) : $urandom_range(1, 3);
         end
         vs_left--;
         cycle(1'($urandom_range(0, 1)), cur_vs, 1'($urandom_range(0, 3) != 0),
               pick(10'd479, 10'd525), pick(10'd639, 10'd799));
      end
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);

      // Counter wrap: preload near the top, then three more frames.
      @(negedge clock);
      force dut.r_frame_count = 16'hFFFD;
      mcount = 16'hFFFD;
      cycle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      release dut.r_frame_count;
      cycle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      frames(3);
      check("wrap", frame_count, 16'h0000);

      // Mid-line reset with vsync active.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 10'd100, 10'd200);
      @(posedge clock);
      #7;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      hist.delete();
      mcount = 16'd0;
      @(negedge clock);
      rel_pending = 1'b1;
      fs_seen = 0;
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 10'd100, 10'd200);
      check("midrst_nofs", fs_seen, 0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 10'd100, 10'd200);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 10'd100, 10'd200);
      cycle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      check("midrst_fs", fs_seen, 1);
      check("midrst_fc", frame_count, 16'd1);

`ifdef VID_WORLD_PIPE_TESTPAT_EN
      // Checkerboard pattern: row_cell 8 / col_cell 0 -> 01, 8/8 -> 10, column 600 -> 00.
      tp_sel = 1'b1;
      cycle(1'b1, 1'b1, 1'b1, 10'd32, 10'd0);
      cycle(1'b1, 1'b1, 1'b1, 10'd32, 10'd32);
      cycle(1'b1, 1'b1, 1'b1, 10'd32, 10'd600);
      check("tp_8_0", pix_o, 2'b01);
      cycle(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      check("tp_8_8", pix_o, 2'b10);
      cycle(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      check("tp_col600", pix_o, 2'b00);
      tp_sel = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
